// File: rtl/rrb_demux_if.sv
// ---------------------------------------------------------------------------
// rrb_demux_if
// Handshake bundle for the rrb_demux return-path distributor.
//
// Upstream side : in_valid, in_ready, sel_one_hot, data_in
// Lane side     : out_valid, out_ready, data_out_bus (lane i on
//                 bits [(i+1)*width-1 -: width])
// Status        : sel_error (one-cycle drop pulse), drop_cnt (saturating)
//
// Modports:
//   master - the environment: drives the upstream word and the lane readies
//   slave  - the distributor itself
// ---------------------------------------------------------------------------
interface rrb_demux_if #(
    parameter int channels = 8,
    parameter int width    = 32
);
    logic                        in_valid;
    logic                        in_ready;
    logic [channels-1:0]         sel_one_hot;
    logic [width-1:0]            data_in;
    logic [channels-1:0]         out_valid;
    logic [channels-1:0]         out_ready;
    logic [channels*width-1:0]   data_out_bus;
    logic                        sel_error;
    logic [7:0]                  drop_cnt;

    modport master (
        output in_valid, sel_one_hot, data_in, out_ready,
        input  in_ready, out_valid, data_out_bus, sel_error, drop_cnt
    );

    modport slave (
        input  in_valid, sel_one_hot, data_in, out_ready,
        output in_ready, out_valid, data_out_bus, sel_error, drop_cnt
    );
endinterface

// File: rtl/rrb_demux.sv
// ---------------------------------------------------------------------------
// rrb_demux
// Return-path distributor: steers each word of one shared stream into one of
// `channels` lanes selected by a one-hot select. Every lane owns a one-entry
// registered slot with valid/ready, so a stalled lane only blocks words that
// are addressed to it. Words with a non-one-hot select are accepted, dropped,
// flagged on sel_error for one cycle and counted in drop_cnt (saturating).
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-high
//   bus    - rrb_demux_if.slave: in_valid/in_ready/sel_one_hot/data_in,
//            out_valid/out_ready/data_out_bus, sel_error, drop_cnt
// ---------------------------------------------------------------------------
module rrb_demux #(
    parameter int channels = 8,
    parameter int width    = 32
) (
    input  logic         clk,
    input  logic         reset,
    rrb_demux_if.slave   bus
);

    logic [channels-1:0] vld_p1;
    logic [width-1:0]    data_p1 [channels];
    logic                sel_error_p1;
    logic [7:0]          drop_cnt_p1;

    logic [channels-1:0] lane_free;
    logic [channels-1:0] fill;
    logic                sel_legal;
    logic                in_ready;
    logic                accept;
    logic                drop;

    // Legal select means exactly one bit set; counted rather than
    // priority-decoded so that multi-bit selects are never silently steered.
    function automatic logic is_one_hot(input logic [channels-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < channels; i++) begin
            n = n + 32'(v[i]);
        end
        return (n == 1);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    // Stage p0: select decode and acceptance (combinational)
    always_comb begin
        lane_free = ~vld_p1 | bus.out_ready;
        sel_legal = is_one_hot(bus.sel_one_hot);
        in_ready  = 1'b0;
        if (!reset) begin
            // With a one-hot select the AND picks out exactly lane d's space.
            in_ready = sel_legal ? |(bus.sel_one_hot & lane_free) : 1'b1;
        end
        accept = bus.in_valid & in_ready;
        fill   = (accept && sel_legal) ? bus.sel_one_hot : '0;
        drop   = accept & ~sel_legal;
    end

    // Stage p1: lane slots and drop status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1       <= '0;
            sel_error_p1 <= 1'b0;
            drop_cnt_p1  <= 8'd0;
            for (int i = 0; i < channels; i++) begin
                data_p1[i] <= '0;
            end
        end else begin
            for (int i = 0; i < channels; i++) begin
                // A fill wins over a same-edge drain so one lane can stream
                // a word every cycle.
                if (fill[i]) begin
                    vld_p1[i]  <= 1'b1;
                    data_p1[i] <= bus.data_in;
                end else if (bus.out_ready[i]) begin
                    vld_p1[i]  <= 1'b0;
                end
            end
            sel_error_p1 <= drop;
            if (drop) begin
                drop_cnt_p1 <= sat_inc(drop_cnt_p1);
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = vld_p1;
    assign bus.sel_error = sel_error_p1;
    assign bus.drop_cnt  = drop_cnt_p1;

    for (genvar g = 0; g < channels; g++) begin : g_lane_out
        assign bus.data_out_bus[g*width +: width] = data_p1[g];
    end

endmodule
